// File: rtl/isqrt_pipe_with_valid_pkg.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_pkg
// Brief    : Shared sizing helpers for the integer square-root pipeline.
// Revision : 1.0
// ============================================================================
package isqrt_pkg;

    // Pipeline depth; latency-balancing shift registers elsewhere use this too.
    function automatic int isqrt_latency(input int width);
        return width / 2;
    endfunction

    function automatic int isqrt_rem_w(input int width);
        return width / 2 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/isqrt_pipe_with_valid_if.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_pipe_with_valid_if
// Brief    : Operand/result bundle for the square-root pipeline.
// Revision : 1.0
// ============================================================================
interface isqrt_pipe_with_valid_if #(
    parameter int WIDTH = 32
) ();
    logic                                   in_vld;
    logic [WIDTH-1:0]                       in_x;
    logic                                   out_vld;
    logic [WIDTH/2-1:0]                     out_root;
    logic [isqrt_pkg::isqrt_rem_w(WIDTH)-1:0] out_rem;

    modport master (output in_vld, in_x, input out_vld, out_root, out_rem);
    modport slave  (input in_vld, in_x, output out_vld, out_root, out_rem);
endinterface
`default_nettype wire

// File: rtl/isqrt_pipe_with_valid_stage.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_stage
// Brief    : One restoring square-root step plus its load-on-valid registers.
// Revision : 1.0
// ============================================================================
module isqrt_stage
    import isqrt_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STAGE = 0
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic                          i_vld,
    input  wire logic [WIDTH-1:0]              i_x,
    input  wire logic [isqrt_rem_w(WIDTH):0]   i_rem,
    input  wire logic [WIDTH/2-1:0]            i_root,
    output logic                               o_vld,
    output logic [WIDTH-1:0]                   o_x,
    output logic [isqrt_rem_w(WIDTH):0]       o_rem,
    output logic [WIDTH/2-1:0]                 o_root
);
    localparam int c_ROOT_W = WIDTH / 2;
    localparam int c_RI_W   = isqrt_rem_w(WIDTH) + 1;
    localparam int c_CMP_W  = isqrt_rem_w(WIDTH) + 2;

    logic [c_RI_W-1:0]   w_rem_in;
    logic [c_ROOT_W-1:0] w_root_in;
    logic [c_CMP_W-1:0]  w_r;
    logic [c_CMP_W-1:0]  w_t;
    logic [c_CMP_W-1:0]  w_diff;
    logic                w_ge;

    logic                r_vld;
    logic [WIDTH-1:0]    r_x;
    logic [c_RI_W-1:0]   r_rem;
    logic [c_ROOT_W-1:0] r_root;

    // The entry stage starts every operation from a zero partial result.
    assign w_rem_in  = (STAGE == 0) ? '0 : i_rem;
    assign w_root_in = (STAGE == 0) ? '0 : i_root;

    assign w_r    = c_CMP_W'({w_rem_in, i_x[WIDTH-1 -: 2]});
    assign w_t    = c_CMP_W'({w_root_in, 2'b01});
    assign w_ge   = (w_r >= w_t);
    assign w_diff = w_r - w_t;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_x    <= '0;
            r_rem  <= '0;
            r_root <= '0;
        end else begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_x <= {i_x[WIDTH-3:0], 2'b00};
                if (w_ge) begin
                    r_rem  <= c_RI_W'(w_diff);
                    r_root <= c_ROOT_W'({w_root_in, 1'b1});
                end else begin
                    r_rem  <= c_RI_W'(w_r);
                    r_root <= c_ROOT_W'({w_root_in, 1'b0});
                end
            end
        end
    end

    assign o_vld  = r_vld;
    assign o_x    = r_x;
    assign o_rem  = r_rem;
    assign o_root = r_root;

endmodule
`default_nettype wire

// File: rtl/isqrt_pipe_with_valid.sv
`default_nettype none
// ============================================================================
// Module   : isqrt_pipe_with_valid
// Brief    : Fully pipelined floor(sqrt(x)) with remainder, one bit per stage.
// Revision : 1.0
// ============================================================================
module isqrt_pipe_with_valid
    import isqrt_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic               clk,
    input  wire logic               rst,
    isqrt_pipe_with_valid_if.slave  bus
);
    localparam int c_LATENCY = isqrt_latency(WIDTH);
    localparam int c_ROOT_W  = WIDTH / 2;
    localparam int c_REM_W   = isqrt_rem_w(WIDTH);

    // Index k is the input of stage k; index c_LATENCY is the last stage output.
    logic                w_vld  [c_LATENCY+1];
    logic [WIDTH-1:0]    w_x    [c_LATENCY+1];
    logic [c_REM_W:0]    w_rem  [c_LATENCY+1];
    logic [c_ROOT_W-1:0] w_root [c_LATENCY+1];

    assign w_vld[0]  = bus.in_vld;
    assign w_x[0]    = bus.in_x;
    assign w_rem[0]  = '0;
    assign w_root[0] = '0;

    for (genvar g = 0; g < c_LATENCY; g++) begin : g_stage
        isqrt_stage #(
            .WIDTH (WIDTH),
            .STAGE (g)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_vld  (w_vld[g]),
            .i_x    (w_x[g]),
            .i_rem  (w_rem[g]),
            .i_root (w_root[g]),
            .o_vld  (w_vld[g+1]),
            .o_x    (w_x[g+1]),
            .o_rem  (w_rem[g+1]),
            .o_root (w_root[g+1])
        );
    end

    assign bus.out_vld  = w_vld[c_LATENCY];
    assign bus.out_root = w_root[c_LATENCY];
    assign bus.out_rem  = w_rem[c_LATENCY][c_REM_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_isqrt_pipe_with_valid.sv
`default_nettype none
// ============================================================================
// Module   : tb_isqrt_pipe_with_valid
// Brief    : Scoreboard bench for the 32-bit and 4-bit square-root pipelines.
// Revision : 1.0
// ============================================================================
module tb_isqrt_pipe_with_valid;
    import isqrt_pkg::*;

    localparam int c_LAT_A = isqrt_latency(32);
    localparam int c_LAT_B = isqrt_latency(4);

    typedef struct {
        logic [31:0] x;
        logic [31:0] root;
        logic [31:0] rem;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    isqrt_pipe_with_valid_if #(.WIDTH(32)) ifa ();
    isqrt_pipe_with_valid_if #(.WIDTH(4))  ifb ();

    isqrt_pipe_with_valid #(.WIDTH(32)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
    isqrt_pipe_with_valid #(.WIDTH(4))  u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

    exp_t        qa[$];
    exp_t        qb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          mon_en = 1'b0;
    logic [31:0] last_root [2];
    logic [31:0] last_rem  [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_root(input logic [31:0] x);
        longint unsigned r = 0;
        longint unsigned c;
        for (int b = 15; b >= 0; b--) begin
            c = r | (64'd1 << b);
            if (c * c <= {32'd0, x}) r = c;
        end
        return r[31:0];
    endfunction

    task automatic cmp(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at cycle %0d", name, d, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input bit v, input logic [31:0] x,
                         input logic [31:0] er, input logic [31:0] em);
        exp_t e;
        if (d == 0) begin
            ifa.in_vld = v;
            ifa.in_x   = x;
        end else begin
            ifb.in_vld = v;
            ifb.in_x   = x[3:0];
        end
        if (v && !rst) begin
            e.x    = x;
            e.root = er;
            e.rem  = em;
            e.due  = cyc + ((d == 0) ? c_LAT_A : c_LAT_B);
            if (d == 0) qa.push_back(e);
            else        qb.push_back(e);
        end
    endtask

    task automatic drive_model(input logic [31:0] x);
        logic [31:0] r;
        r = ref_root(x);
        drive(0, 1'b1, x, r, x - r * r);
    endtask

    task automatic mon(input int d, input logic v, input logic [31:0] root, input logic [31:0] rem);
        exp_t            e;
        int              n;
        longint unsigned rr;
        n = (d == 0) ? qa.size() : qb.size();
        if (v) begin
            if (n == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_vld dut%0d: got out_vld=1 expected 0 at cycle %0d", d, cyc);
            end else begin
                if (d == 0) e = qa.pop_front();
                else        e = qb.pop_front();
                cmp("root", d, root, e.root);
                cmp("rem", d, rem, e.rem);
                cmp("latency", d, 32'(cyc), 32'(e.due));
                if (d == 0) begin
                    rr = {32'd0, root};
                    checks++;
                    if (!(rr * rr <= {32'd0, e.x} && {32'd0, e.x} < (rr + 1) * (rr + 1))) begin
                        errors++;
                        $display("FAIL root_bound dut0: got root %0h for x %0h", root, e.x);
                    end
                end
            end
            last_root[d] = root;
            last_rem[d]  = rem;
        end else begin
            cmp("hold_root", d, root, last_root[d]);
            cmp("hold_rem", d, rem, last_rem[d]);
            if (n > 0) begin
                e = (d == 0) ? qa[0] : qb[0];
                if (e.due <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_vld dut%0d: got out_vld=0 expected 1 at cycle %0d", d, cyc);
                    if (d == 0) void'(qa.pop_front());
                    else        void'(qb.pop_front());
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, ifa.out_vld, 32'(ifa.out_root), 32'(ifa.out_rem));
            mon(1, ifb.out_vld, 32'(ifb.out_root), 32'(ifb.out_rem));
        end
    end

    task automatic check_reset_state();
        cmp("rst_vld", 0, 32'(ifa.out_vld), 32'd0);
        cmp("rst_root", 0, 32'(ifa.out_root), 32'd0);
        cmp("rst_rem", 0, 32'(ifa.out_rem), 32'd0);
        cmp("rst_vld", 1, 32'(ifb.out_vld), 32'd0);
        cmp("rst_root", 1, 32'(ifb.out_root), 32'd0);
        cmp("rst_rem", 1, 32'(ifb.out_rem), 32'd0);
    endtask

    // Hand-computed single-operand vectors: {x, root, rem}
    logic [31:0] dir_tab [8][3] = '{
        '{32'd0,        32'd0,      32'd0},
        '{32'd99,       32'd9,      32'd18},
        '{32'd1000000,  32'd1000,   32'd0},
        '{32'hFFFFFFFF, 32'hFFFF,   32'h1FFFE},
        '{32'd2,        32'd1,      32'd1},
        '{32'd48,       32'd6,      32'd12},
        '{32'hFFFE0001, 32'hFFFF,   32'd0},
        '{32'h40000000, 32'h8000,   32'd0}
    };
    logic [31:0] b_root [16] = '{0, 1, 1, 1, 2, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3};
    logic [31:0] b_rem  [16] = '{0, 0, 1, 2, 0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 5, 6};

    initial begin
        ifa.in_vld = 1'b0;
        ifa.in_x   = '0;
        ifb.in_vld = 1'b0;
        ifb.in_x   = '0;
        rst = 1'b1;
        repeat (2) step();
        check_reset_state();
        last_root = '{32'd0, 32'd0};
        last_rem  = '{32'd0, 32'd0};
        rst    = 1'b0;
        mon_en = 1'b1;

        // Isolated operands separated by idle cycles.
        for (int i = 0; i < 8; i++) begin
            drive(0, 1'b1, dir_tab[i][0], dir_tab[i][1], dir_tab[i][2]);
            step();
            drive(0, 1'b0, 32'd0, 32'd0, 32'd0);
            repeat (3) step();
        end

        // Narrow pipeline, exhaustive and back-to-back.
        for (int i = 0; i < 16; i++) begin
            drive(1, 1'b1, 32'(i), b_root[i], b_rem[i]);
            step();
        end
        drive(1, 1'b0, 32'd0, 32'd0, 32'd0);

        // Continuous stream.
        for (int i = 0; i < 300; i++) begin
            drive_model(32'(i));
            step();
        end

        // Random valid pattern with random operands.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 1) == 1) drive_model($urandom);
            else drive(0, 1'b0, 32'd0, 32'd0, 32'd0);
            step();
        end
        drive(0, 1'b0, 32'd0, 32'd0, 32'd0);
        repeat (20) step();

        // Reset with eight operations in flight and in_vld high during reset.
        for (int i = 0; i < 8; i++) begin
            drive_model(32'(1000 + i));
            step();
        end
        rst = 1'b1;
        drive(0, 1'b1, 32'd12345, 32'd0, 32'd0);
        step();
        qa.delete();
        qb.delete();
        last_root = '{32'd0, 32'd0};
        last_rem  = '{32'd0, 32'd0};
        check_reset_state();
        rst = 1'b0;
        drive(0, 1'b0, 32'd0, 32'd0, 32'd0);
        repeat (5) step();
        drive(0, 1'b1, 32'd144, 32'd12, 32'd0);
        step();
        drive(0, 1'b0, 32'd0, 32'd0, 32'd0);

        for (int k = 0; k < 200 && (qa.size() != 0 || qb.size() != 0); k++) step();
        if (qa.size() != 0 || qb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d results outstanding expected 0", qa.size() + qb.size());
        end
        repeat (20) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
